// File: rtl/reg_cmd_ctrl_if.sv
// reg_cmd_ctrl_if: RX byte stream, register-file port and TX handshake of the command controller
interface reg_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_d_vld;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_vld;
    logic                  tx_busy;
    logic                  cmd_err;
    modport master (
        input  rx_p_data, rx_d_vld, rd_data, rd_data_valid, tx_busy,
        output wr_en, rd_en, address, wr_data, tx_p_data, tx_d_vld, cmd_err
    );
    modport slave (
        output rx_p_data, rx_d_vld, rd_data, rd_data_valid, tx_busy,
        input  wr_en, rd_en, address, wr_data, tx_p_data, tx_d_vld, cmd_err
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: parses UART command bytes into register-file strobes and returns read data to TX
module reg_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 4
) (
    input logic            clk,
    input logic            rst_n,
    reg_cmd_ctrl_if.master bus
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RD_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);
    localparam logic [2:0] IDLE = 3'd0, WR_ADDR = 3'd1, WR_DATA = 3'd2, WR_EXEC = 3'd3,
                           RD_ADDR = 3'd4, RD_EXEC = 3'd5, RD_WAIT = 3'd6, TX_SEND = 3'd7;
    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  vld;
    logic                  addr_ok;
    assign vld = bus.rx_d_vld;
    assign addr_ok = (bus.rx_p_data >> ADDR_WIDTH) == '0;
    always_comb begin
        state_d = state_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (vld) begin
                state_d = (bus.rx_p_data == OP_WR) ? WR_ADDR : (bus.rx_p_data == OP_RD) ? RD_ADDR : IDLE;
                err_d = bus.rx_p_data != OP_WR && bus.rx_p_data != OP_RD;
            end
            WR_ADDR, RD_ADDR: if (vld) begin
                err_d = !addr_ok;
                state_d = !addr_ok ? IDLE : (state_q == WR_ADDR) ? WR_DATA : RD_EXEC;
                address_d = addr_ok ? bus.rx_p_data[ADDR_WIDTH-1:0] : address_q;
            end
            WR_DATA: if (vld) begin
                wr_data_d = bus.rx_p_data;
                state_d = WR_EXEC;
            end
            WR_EXEC: begin
                err_d = vld;
                state_d = IDLE;
            end
            RD_EXEC: begin
                err_d = vld;
                cnt_d = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                err_d = vld || (!bus.rd_data_valid && cnt_q == CNT_LAST);
                tx_data_d = bus.rd_data_valid ? bus.rd_data : tx_data_q;
                state_d = bus.rd_data_valid ? TX_SEND : (cnt_q == CNT_LAST) ? IDLE : RD_WAIT;
            end
            default: begin
                err_d = vld;
                state_d = bus.tx_busy ? TX_SEND : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            address_q <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.wr_en = state_q == WR_EXEC;
    assign bus.rd_en = state_q == RD_EXEC;
    assign bus.tx_d_vld = state_q == TX_SEND && !bus.tx_busy;
    assign bus.address = address_q;
    assign bus.wr_data = wr_data_q;
    assign bus.tx_p_data = tx_data_q;
    assign bus.cmd_err = err_q;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: random command stream checked against an event-level model of the controller
module tb_reg_cmd_ctrl;
    localparam int T = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    reg_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
    reg_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_until = 0;
    bit stray = 0;
    bit rf_enable = 1;
    bit rf_pending = 0;
    bit prev_strobe = 0;
    logic [7:0] rf_data;
    logic [7:0] rf_mem [16];
    logic [7:0] ref_mem [16];
    logic [63:0] act_wr[$], act_rd[$], act_tx[$], act_err[$];
    logic [63:0] exp_wr[$], exp_rd[$], exp_tx[$], exp_err[$];
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    function automatic logic [63:0] ev(input int c, input logic [7:0] hi, input logic [7:0] lo);
        return (64'(c) << 16) | (64'(hi) << 8) | 64'(lo);
    endfunction
    task automatic tick(input bit vld, input logic [7:0] b, input bit rst);
        int c;
        @(posedge clk);
        #1;
        c = cyc + 1;
        rst_n = !rst;
        if (rst) rf_pending = 0;
        bus.rx_d_vld = vld;
        bus.rx_p_data = b;
        bus.tx_busy = c < busy_until;
        bus.rd_data_valid = rf_pending || (stray && $urandom_range(0, 1) == 1);
        bus.rd_data = rf_pending ? rf_data : 8'($urandom);
        rf_pending = 0;
        @(negedge clk);
        cyc = c;
        check("excl", 64'(bus.wr_en & bus.rd_en), 0);
        check("single", 64'((bus.wr_en | bus.rd_en) & prev_strobe), 0);
        prev_strobe = bus.wr_en | bus.rd_en;
        if (rst) check("rst_out", 64'({bus.wr_en, bus.rd_en, bus.tx_d_vld, bus.cmd_err, bus.address, bus.wr_data, bus.tx_p_data}), 0);
        if (bus.wr_en) begin
            act_wr.push_back(ev(c, 8'(bus.address), bus.wr_data));
            rf_mem[bus.address] = bus.wr_data;
        end
        if (bus.rd_en) begin
            act_rd.push_back(ev(c, 0, 0));
            rf_pending = rf_enable;
            rf_data = rf_mem[bus.address];
        end
        if (bus.tx_d_vld) act_tx.push_back(ev(c, 0, bus.tx_p_data));
        if (bus.cmd_err) act_err.push_back(ev(c, 0, 0));
    endtask
    task automatic send(input logic [7:0] b, output int c);
        repeat ($urandom_range(0, 2)) tick(0, 8'($urandom), 0);
        tick(1, b, 0);
        c = cyc;
    endtask
    task automatic cmp_q(input string tag, input logic [63:0] act[$], input logic [63:0] exp[$]);
        check({tag, "_cnt"}, 64'(act.size()), 64'(exp.size()));
        foreach (exp[i]) if (i < act.size()) check(tag, act[i], exp[i]);
    endtask
    task automatic drain(input int n);
        repeat (n) tick(0, 8'($urandom), 0);
        cmp_q("wr", act_wr, exp_wr);
        cmp_q("rd", act_rd, exp_rd);
        cmp_q("tx", act_tx, exp_tx);
        cmp_q("err", act_err, exp_err);
        act_wr.delete(); act_rd.delete(); act_tx.delete(); act_err.delete();
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_err.delete();
    endtask
    task automatic do_write(input logic [7:0] ab, input logic [7:0] data, input bit extra);
        int c, a, d;
        send(8'hAA, c);
        send(ab, a);
        if (ab[7:4] != 0) begin
            exp_err.push_back(ev(a + 1, 0, 0));
        end else begin
            send(data, d);
            exp_wr.push_back(ev(d + 1, ab, data));
            ref_mem[ab[3:0]] = data;
            if (extra) begin
                tick(1, 8'($urandom), 0);
                exp_err.push_back(ev(d + 2, 0, 0));
            end
        end
        stray = 1;
        drain(6);
        stray = 0;
    endtask
    task automatic do_read(input logic [7:0] ab, input bit rf_on, input int bl, input bit extra);
        int c, a;
        bit inj;
        logic [7:0] exp;
        send(8'hBB, c);
        send(ab, a);
        exp = ref_mem[ab[3:0]];
        if (ab[7:4] != 0) begin
            exp_err.push_back(ev(a + 1, 0, 0));
            drain(4);
            return;
        end
        rf_enable = rf_on;
        busy_until = a + 3 + bl;
        exp_rd.push_back(ev(a + 1, 0, 0));
        if (rf_on) exp_tx.push_back(ev(a + 3 + bl, 0, exp));
        else exp_err.push_back(ev(a + 2 + T, 0, 0));
        for (int i = 0; i < 20; i++) begin
            inj = extra && rf_on && bl > 0 && cyc + 1 == a + 3;
            tick(inj, 8'($urandom), 0);
            if (inj) exp_err.push_back(ev(a + 4, 0, 0));
            if (rf_on && cyc >= a + 3 && cyc <= a + 3 + bl) check("tx_hold", 64'(bus.tx_p_data), 64'(exp));
        end
        rf_enable = 1;
        drain(0);
    endtask
    task automatic bad_op(input logic [7:0] b);
        int c;
        send(b, c);
        exp_err.push_back(ev(c + 1, 0, 0));
        drain(4);
    endtask
    initial begin
        int c;
        logic [7:0] b;
        bus.rx_d_vld = 0;
        bus.rx_p_data = 0;
        bus.rd_data = 0;
        bus.rd_data_valid = 0;
        bus.tx_busy = 0;
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = 8'($urandom);
            ref_mem[i] = rf_mem[i];
        end
        repeat (3) tick(0, 0, 1);
        drain(2);
        do_write(8'h05, 8'h3C, 0);
        do_read(8'h05, 1, 0, 0);
        do_read(8'h05, 1, 8, 1);
        bad_op(8'h12);
        do_write(8'h25, 8'h77, 0);
        do_read(8'h02, 1, 0, 0);
        do_read(8'h02, 0, 0, 0);
        send(8'hAA, c);
        send(8'h05, c);
        tick(0, 0, 1);
        drain(6);
        do_write(8'h05, 8'h3C, 0);
        do_read(8'h05, 1, 1, 0);
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 4))
                0, 1: do_write(($urandom_range(0, 4) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom)},
                               8'($urandom), $urandom_range(0, 3) == 0);
                2, 3: do_read(($urandom_range(0, 5) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom)},
                              $urandom_range(0, 4) != 0, $urandom_range(0, 10), $urandom_range(0, 2) == 0);
                default: begin
                    do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB);
                    bad_op(b);
                end
            endcase
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
